// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared FSM, reset PC and branch-unit control encodings
package pc_fetch_unit_pkg;
   typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;
   typedef enum logic [1:0] {CTL_SEQ = 2'b00, CTL_BRANCH = 2'b01, CTL_JUMP = 2'b10} ctl_t;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES = 32'd4;
   function automatic ctl_t ctl_enc(input logic jmp, input logic taken);
      return jmp ? CTL_JUMP : (taken ? CTL_BRANCH : CTL_SEQ);
   endfunction
endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// next_pc_sel: priority mux of jump target, taken-branch and sequential next PC
module next_pc_sel
   import pc_fetch_unit_pkg::*;
(
   input  logic        jmp,
   input  logic        branch,
   input  logic        br_cond,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] offset,
   input  logic [31:0] target,
   output logic [31:0] next_pc
);
   ctl_t ctl;
   assign ctl = ctl_enc(jmp, branch & br_cond);
   assign next_pc = (ctl == CTL_JUMP) ? target : (ctl == CTL_BRANCH) ? pc_plus4 + offset : pc_plus4;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC and request/response instruction fetch sequencer
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jmp,
   input  logic        branch,
   input  logic        br_cond,
   input  logic [31:0] offset,
   input  logic [31:0] target,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr_cnt,
   output logic        resp_err
);
   state_t      state;
   logic [31:0] next_pc;
   next_pc_sel u_next_pc_sel (
      .jmp      (jmp),
      .branch   (branch),
      .br_cond  (br_cond),
      .pc_plus4 (pc_plus4),
      .offset   (offset),
      .target   (target),
      .next_pc  (next_pc)
   );
   assign imem_req    = state == REQ;
   assign instr_valid = state == HOLD;
   assign imem_addr   = pc;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= REQ;
         pc        <= RESET_PC;
         pc_plus4  <= RESET_PC + WORD_BYTES;
         instr     <= 32'h0000_0000;
         instr_cnt <= 32'h0000_0000;
         resp_err  <= 1'b0;
      end else begin
         // a response is only legitimate while a fetch is outstanding
         if (imem_rvalid && state != WAIT) resp_err <= 1'b1;
         case (state)
            REQ:  if (imem_ready) state <= WAIT;
            WAIT: if (imem_rvalid) begin
               instr <= imem_rdata;
               state <= HOLD;
            end
            HOLD: if (!stall) begin
               pc        <= next_pc;
               pc_plus4  <= next_pc + WORD_BYTES;
               instr_cnt <= instr_cnt + 32'd1;
               state     <= REQ;
            end
            default: state <= REQ;
         endcase
      end
   end
endmodule
